adc_uart_framer: RTL and testbench

ADC_UART_FRAMER -- requirements
Module: adc_uart_framer

---
 rtl/adc_uart_pkg.sv | 25 ++
 rtl/frame_tick_gen.sv | 29 ++
 rtl/adc_uart_framer.sv | 132 +++++++++++++
 tb/tb_adc_uart_framer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_uart_pkg.sv
// Shared definitions for the ADC-to-UART ASCII framer.
// Holds the framer state encoding, frame length, the ASCII punctuation
// bytes and the nibble-to-ASCII helper used by the byte mux.
package adc_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_LEN = 25;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame period tick generator.
// A free-running counter counts 0..TICK_DIV-1 and wraps; tick is high for
// the single cycle in which the count equals TICK_DIV-1.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (counter to 0)
//   tick - one-cycle frame tick
module frame_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/adc_uart_framer.sv
// ADC sample framer for a UART byte transmitter.
// On every frame tick the eight ADC0809 channel samples are snapshotted and
// sent as the 25-byte ASCII line "HH,HH,HH,HH,HH,HH,HH,HH\r\n" over a
// valid/ready byte interface. Ticks arriving mid-frame are dropped and
// flagged on the sticky overrun output.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, aborts any frame
//   adc_data - eight 8-bit samples, element n is channel n
//   tx_data  - ASCII byte to transmitter
//   tx_valid - tx_data valid
//   tx_ready - transmitter accepts a byte this cycle
//   busy     - frame in progress (SNAP, SEND, DONE)
//   overrun  - sticky: a tick occurred while busy
module adc_uart_framer
  import adc_uart_pkg::*;
#(
  parameter int CLK_FRE  = 50,
  parameter int SEND_FRE = 2,
  parameter int TICK_DIV = CLK_FRE * 1000000 / SEND_FRE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0][7:0] adc_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            overrun
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  logic            tick;
  state_t          state;
  logic [4:0]      idx;
  logic [7:0][7:0] snap;

  logic [7:0][7:0] sel_src;
  logic [4:0]      sel_idx;
  logic [3:0]      nib;
  logic            is_hex;
  logic [7:0]      next_byte;

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Byte mux: picks the byte to load into tx_data next. In SNAP the snapshot
  // register is still being written, so byte 0 is taken straight from
  // adc_data; in SEND the following byte comes from the snapshot.
  always_comb begin
    sel_src = snap;
    sel_idx = idx + 5'd1;
    if (state == SNAP) begin
      sel_src = adc_data;
      sel_idx = '0;
    end
    nib    = '0;
    is_hex = 1'b0;
    // Channel n occupies bytes 3n (upper digit), 3n+1 (lower digit), 3n+2 (separator)
    for (int n = 0; n < 8; n++) begin
      if (sel_idx == 5'(3 * n)) begin
        nib    = sel_src[n][7:4];
        is_hex = 1'b1;
      end else if (sel_idx == 5'(3 * n + 1)) begin
        nib    = sel_src[n][3:0];
        is_hex = 1'b1;
      end
    end
    if (sel_idx == LAST_IDX)                  next_byte = ASCII_LF;
    else if (sel_idx == LAST_IDX - 5'd1)      next_byte = ASCII_CR;
    else if (is_hex)                          next_byte = nib_to_ascii(nib);
    else                                      next_byte = ASCII_COMMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      snap     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          snap     <= adc_data;
          idx      <= '0;
          tx_data  <= next_byte;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          // tx_valid is always high here, so tx_ready alone marks a transfer
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              idx      <= '0;
              state    <= DONE;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= next_byte;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Self-checking bench for adc_uart_framer with TICK_DIV=100.
module tb_adc_uart_framer;

  localparam int TD = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0][7:0] adc_data;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            overrun;

  adc_uart_framer #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst     (rst),
    .adc_data(adc_data),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Rising edges since the last edge that sampled rst=1
  int k;
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  typedef struct {
    logic [7:0][7:0] adc;
    string           txt;
  } vec_t;

  vec_t       tbl[4];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] gotq[$];
  logic [7:0] modq[$];
  logic [7:0] tblq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [7:0] q[$]);
    int bad;
    bad = -1;
    n_vec++;
    if (gotq.size() != q.size()) bad = 999;
    else
      for (int i = 0; i < q.size(); i++)
        if (bad < 0 && gotq[i] !== q[i]) bad = i;
    if (bad == 999) begin
      n_err++;
      $display("FAIL %s: got %0d bytes expected %0d", name, gotq.size(), q.size());
    end else if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, bad, gotq[bad], q[bad]);
    end
  endtask

  // Reference: the ASCII line implied by the channel values
  task automatic build_model(input logic [7:0][7:0] d);
    string hx;
    hx = "0123456789ABCDEF";
    modq.delete();
    for (int n = 0; n < 8; n++) begin
      modq.push_back(hx.getc(int'(d[n] / 16)));
      modq.push_back(hx.getc(int'(d[n] % 16)));
      if (n < 7) modq.push_back(8'h2C);
    end
    modq.push_back(8'h0D);
    modq.push_back(8'h0A);
  endtask

  task automatic from_str(input string s);
    tblq.delete();
    for (int i = 0; i < s.len(); i++) tblq.push_back(s.getc(i));
    tblq.push_back(8'h0D);
    tblq.push_back(8'h0A);
  endtask

  // Called at a negedge; returns at the negedge where tx_valid is first seen
  task automatic wait_first_valid(input int bound, output bit ok);
    int i;
    i = 0;
    tx_ready = 1'b1;
    while (tx_valid !== 1'b1 && i < bound) begin
      @(negedge clk);
      i++;
    end
    ok = (tx_valid === 1'b1);
  endtask

  // Ready pattern: 0 always, 1 one-high-three-low, 2 random, 3 low for 150 cycles
  task automatic collect(input int mode, output int cycles, output bit hold_ok, output bit busy_ok);
    logic [7:0] pd;
    bit         pstall;
    bit         r;
    int         j;
    gotq.delete();
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    pstall  = 1'b0;
    pd      = '0;
    j       = 0;
    while (gotq.size() < 25 && j < 2000) begin
      if (tx_valid !== 1'b1) hold_ok = 1'b0;
      if (pstall && tx_data !== pd) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      case (mode)
        0:       r = 1'b1;
        1:       r = (j % 4 == 0);
        2:       r = 1'($urandom_range(0, 1));
        default: r = (j >= 150);
      endcase
      tx_ready = r;
      if (tx_valid === 1'b1 && r) gotq.push_back(tx_data);
      pstall = (tx_valid === 1'b1) && !r;
      pd     = tx_data;
      j++;
      @(negedge clk);
    end
    cycles = j;
  endtask

  task automatic check_done_idle(input string tag);
    chk({tag, "_done_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_done_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit              ok;
    bit              hold_ok;
    bit              busy_ok;
    int              cyc;
    bit              quiet;
    logic [7:0][7:0] d;

    tbl[0].adc = {8'hC3, 8'h09, 8'hA5, 8'h5A, 8'hFF, 8'h80, 8'h1F, 8'h00};
    tbl[0].txt = "00,1F,80,FF,5A,A5,09,C3";
    tbl[1].adc = {8{8'hEE}};
    tbl[1].txt = "EE,EE,EE,EE,EE,EE,EE,EE";
    tbl[2].adc = {8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    tbl[2].txt = "01,23,45,67,89,AB,CD,EF";
    tbl[3].adc = {8'h0A, 8'hB0, 8'hF9, 8'h90, 8'hA9, 8'h0F, 8'hF0, 8'h9A};
    tbl[3].txt = "9A,F0,0F,A9,90,F9,B0,0A";

    rst      = 1'b1;
    tx_ready = 1'b0;
    adc_data = tbl[0].adc;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    // Table: back-to-back frames, adc_data changed right after each snapshot
    for (int v = 0; v < 4; v++) begin
      adc_data = tbl[v].adc;
      wait_first_valid(250, ok);
      chk("tbl_first_valid", 64'(ok), 64'd1);
      chk("tbl_latency", 64'(k % TD), 64'd1);
      adc_data = (v < 3) ? tbl[v + 1].adc : ~tbl[v].adc;
      collect(0, cyc, hold_ok, busy_ok);
      chk("tbl_cycles", 64'(cyc), 64'd25);
      chk("tbl_valid_hold", 64'(hold_ok), 64'd1);
      from_str(tbl[v].txt);
      chk_frame("tbl_frame_vs_table", tblq);
      build_model(tbl[v].adc);
      chk_frame("tbl_frame_vs_model", modq);
      check_done_idle("tbl");
    end
    chk("no_overrun_yet", 64'(overrun), 64'd0);

    // One cycle high, three low
    adc_data = tbl[0].adc;
    wait_first_valid(250, ok);
    chk("stall_first_valid", 64'(ok), 64'd1);
    collect(1, cyc, hold_ok, busy_ok);
    chk("stall_cycles", 64'(cyc), 64'd97);
    chk("stall_hold", 64'(hold_ok), 64'd1);
    from_str(tbl[0].txt);
    chk_frame("stall_frame", tblq);
    check_done_idle("stall");

    // Long back-pressure: a second tick lands mid-frame
    adc_data = tbl[2].adc;
    wait_first_valid(250, ok);
    chk("ovr_first_valid", 64'(ok), 64'd1);
    collect(3, cyc, hold_ok, busy_ok);
    chk("ovr_cycles", 64'(cyc), 64'd175);
    chk("ovr_hold", 64'(hold_ok), 64'd1);
    chk("ovr_busy_throughout", 64'(busy_ok), 64'd1);
    chk("ovr_overrun", 64'(overrun), 64'd1);
    build_model(tbl[2].adc);
    chk_frame("ovr_frame", modq);
    check_done_idle("ovr");
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) quiet = 1'b0;
    end
    chk("ovr_quiet_after", 64'(quiet), 64'd1);

    // Random samples, random back-pressure
    for (int t = 0; t < 6; t++) begin
      d = {$urandom(), $urandom()};
      adc_data = d;
      wait_first_valid(250, ok);
      chk("rnd_first_valid", 64'(ok), 64'd1);
      chk("rnd_latency", 64'(k % TD), 64'd1);
      adc_data = {$urandom(), $urandom()};
      collect(2, cyc, hold_ok, busy_ok);
      chk("rnd_hold", 64'(hold_ok), 64'd1);
      build_model(d);
      chk_frame("rnd_frame", modq);
      check_done_idle("rnd");
    end
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a frame at byte index 10
    adc_data = tbl[3].adc;
    wait_first_valid(250, ok);
    chk("rstmid_first_valid", 64'(ok), 64'd1);
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    build_model(tbl[3].adc);
    chk("rstmid_byte10", 64'(tx_data), 64'(modq[10]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_tx_valid", 64'(tx_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_overrun", 64'(overrun), 64'd0);
    adc_data = tbl[1].adc;
    wait_first_valid(250, ok);
    chk("rstmid_restart_valid", 64'(ok), 64'd1);
    chk("rstmid_restart_time", 64'(k), 64'd101);
    collect(0, cyc, hold_ok, busy_ok);
    chk("rstmid_cycles", 64'(cyc), 64'd25);
    from_str(tbl[1].txt);
    chk_frame("rstmid_frame", tblq);
    check_done_idle("rstmid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
